// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter that shares one waitrequest-style memory slave between
// the CPU fetch port and data port, with a sticky stall watchdog.
module mips_mem_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t          state, state_nxt;
  logic            last_gnt, last_gnt_nxt;
  logic [CW-1:0]   stall_cnt;
  logic            i_req, d_req;
  logic            stalling;

  // Handshake: a master holds its strobe (and address/data) until it sees its
  // waitrequest low on a cycle where the strobe is high; that cycle completes it.
  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= SIDE_D;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = (last_gnt == SIDE_D) ? GNT_I : GNT_D;
        else if (i_req)     state_nxt = GNT_I;
        else if (d_req)     state_nxt = GNT_D;
        else                state_nxt = IDLE;
      end
      GNT_I: begin
        // A dropped strobe abandons the grant without taking a round-robin turn.
        if (!i_req) begin
          state_nxt = IDLE;
        end else if (!m_waitrequest) begin
          state_nxt    = IDLE;
          last_gnt_nxt = SIDE_I;
        end
      end
      GNT_D: begin
        if (!d_req) begin
          state_nxt = IDLE;
        end else if (!m_waitrequest) begin
          state_nxt    = IDLE;
          last_gnt_nxt = SIDE_D;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_byteenable  = '0;
    m_writedata   = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state)
      GNT_I: begin
        m_address     = i_address;
        m_read        = i_read;
        m_byteenable  = 4'hF;
        i_waitrequest = m_waitrequest;
      end
      GNT_D: begin
        m_address     = d_address;
        m_read        = d_read & ~d_write;
        m_write       = d_write;
        m_byteenable  = d_byteenable;
        m_writedata   = d_writedata;
        d_waitrequest = m_waitrequest;
      end
      default: ;
    endcase
  end

  assign i_readdata = m_readdata;
  assign d_readdata = m_readdata;

  // The flag is raised on the edge that brings the counter to TIMEOUT; the
  // grant itself keeps waiting on the slave.
  assign stalling = (state != IDLE) && m_waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!stalling)
        stall_cnt <= '0;
      else if (stall_cnt != CW'(TIMEOUT))
        stall_cnt <= stall_cnt + CW'(1);
      if (stalling && (stall_cnt >= CW'(TIMEOUT - 1)))
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a per-cycle vector table plus
// hand-written sequences for the watchdog and asynchronous reset.
module tb_mips_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        timeout_err;

  mips_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_waitrequest(i_waitrequest),
    .i_readdata   (i_readdata),
    .d_address    (d_address),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_byteenable (d_byteenable),
    .d_writedata  (d_writedata),
    .d_waitrequest(d_waitrequest),
    .d_readdata   (d_readdata),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest),
    .m_readdata   (m_readdata),
    .timeout_err  (timeout_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

  // ---------------- types and bookkeeping ----------------
  typedef struct packed {
    logic [31:0] ma;
    logic        mr;
    logic        mwr;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    logic        iw;
    logic        dw;
    logic [31:0] ird;
    logic [31:0] drd;
    logic        te;
  } out_t;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic        mw;
    logic [31:0] mrd;
    out_t        exp;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  vec_t        vq[$];
  logic [31:0] exp_q[$];

  localparam logic [31:0] A0 = 32'hBFC00000;
  localparam logic [31:0] A4 = 32'hBFC00004;
  localparam logic [31:0] W1 = 32'h12345678;
  localparam logic [31:0] W2 = 32'h9ABCDEF0;
  localparam logic [31:0] W3 = 32'h0BADF00D;
  localparam logic [31:0] W5 = 32'hFEEDBEEF;

  // ---------------- expected-output builders ----------------
  function automatic out_t o_idle(input logic [31:0] rd);
    out_t o;
    o = '{ma: 32'h0, mr: 1'b0, mwr: 1'b0, mbe: 4'h0, mwd: 32'h0,
          iw: 1'b1, dw: 1'b1, ird: rd, drd: rd, te: 1'b0};
    return o;
  endfunction

  function automatic out_t o_gi(input logic [31:0] a, input logic mr,
                                input logic mw, input logic [31:0] rd);
    out_t o;
    o = '{ma: a, mr: mr, mwr: 1'b0, mbe: 4'hF, mwd: 32'h0,
          iw: mw, dw: 1'b1, ird: rd, drd: rd, te: 1'b0};
    return o;
  endfunction

  function automatic out_t o_gd(input logic [31:0] a, input logic mr, input logic mwr,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic mw, input logic [31:0] rd);
    out_t o;
    o = '{ma: a, mr: mr, mwr: mwr, mbe: be, mwd: wd,
          iw: 1'b1, dw: mw, ird: rd, drd: rd, te: 1'b0};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{ma: m_address, mr: m_read, mwr: m_write, mbe: m_byteenable,
          mwd: m_writedata, iw: i_waitrequest, dw: d_waitrequest,
          ird: i_readdata, drd: d_readdata, te: timeout_err};
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add(input logic rst, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [3:0] dbe, input logic [31:0] dwd,
                     input logic mw, input logic [31:0] mrd, input out_t e);
    vec_t v;
    v = '{rst: rst, ir: ir, ia: ia, dr: dr, dw: dw, da: da, dbe: dbe,
          dwd: dwd, mw: mw, mrd: mrd, exp: e};
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    i_read        = v.ir;
    i_address     = v.ia;
    d_read        = v.dr;
    d_write       = v.dw;
    d_address     = v.da;
    d_byteenable  = v.dbe;
    d_writedata   = v.dwd;
    m_waitrequest = v.mw;
    m_readdata    = v.mrd;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0;
    d_byteenable = '0; d_writedata = '0;
    m_waitrequest = 1'b0; m_readdata = '0;
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_o(input int idx, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d: got %h expected %h", idx, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    clear_inputs();

    // Reset held with a fetch pending, then a single fetch from the reset vector.
    add(1, 1, A0, 0, 0, 32'h0, 4'h0, 32'h0, 0, W1, o_idle(W1));
    add(1, 1, A0, 0, 0, 32'h0, 4'h0, 32'h0, 0, W1, o_idle(W1));
    add(0, 1, A0, 0, 0, 32'h0, 4'h0, 32'h0, 0, W1, o_idle(W1));
    add(0, 1, A0, 0, 0, 32'h0, 4'h0, 32'h0, 0, W1, o_gi(A0, 1, 0, W1));
    // Fetch and write both held from reset: I, D, I alternate with IDLE between.
    add(1, 1, A4, 0, 1, 32'h10, 4'h3, 32'hCAFEF00D, 0, W2, o_idle(W2));
    add(0, 1, A4, 0, 1, 32'h10, 4'h3, 32'hCAFEF00D, 0, W2, o_idle(W2));
    add(0, 1, A4, 0, 1, 32'h10, 4'h3, 32'hCAFEF00D, 0, W2, o_gi(A4, 1, 0, W2));
    add(0, 1, A4, 0, 1, 32'h10, 4'h3, 32'hCAFEF00D, 0, W2, o_idle(W2));
    add(0, 1, A4, 0, 1, 32'h10, 4'h3, 32'hCAFEF00D, 0, W2,
        o_gd(32'h10, 0, 1, 4'h3, 32'hCAFEF00D, 0, W2));
    add(0, 1, A4, 0, 1, 32'h10, 4'h3, 32'hCAFEF00D, 0, W2, o_idle(W2));
    add(0, 1, A4, 0, 1, 32'h10, 4'h3, 32'hCAFEF00D, 0, W2, o_gi(A4, 1, 0, W2));
    // Data read stalled 5 cycles while the fetch is held off.
    add(0, 1, A4, 1, 0, 32'h20, 4'h3, 32'hCAFEF00D, 1, W3, o_idle(W3));
    for (int k = 0; k < 5; k++)
      add(0, 1, A4, 1, 0, 32'h20, 4'h3, 32'hCAFEF00D, 1, W3,
          o_gd(32'h20, 1, 0, 4'h3, 32'hCAFEF00D, 1, W3));
    add(0, 1, A4, 1, 0, 32'h20, 4'h3, 32'hCAFEF00D, 0, W3,
        o_gd(32'h20, 1, 0, 4'h3, 32'hCAFEF00D, 0, W3));
    add(0, 1, A4, 0, 0, 32'h20, 4'h3, 32'hCAFEF00D, 0, W3, o_idle(W3));
    add(0, 1, A4, 0, 0, 32'h20, 4'h3, 32'hCAFEF00D, 0, W3, o_gi(A4, 1, 0, W3));
    // Read and write together: write wins.
    add(0, 0, A4, 1, 1, 32'h40, 4'hF, 32'h55AA55AA, 0, W3, o_idle(W3));
    add(0, 0, A4, 1, 1, 32'h40, 4'hF, 32'h55AA55AA, 0, W3,
        o_gd(32'h40, 0, 1, 4'hF, 32'h55AA55AA, 0, W3));
    // Fetch dropped mid-stall: back to IDLE, turn stays with D so the tie goes to I.
    add(0, 1, A4, 0, 0, 32'h40, 4'hF, 32'h55AA55AA, 1, W3, o_idle(W3));
    add(0, 1, A4, 0, 0, 32'h40, 4'hF, 32'h55AA55AA, 1, W3, o_gi(A4, 1, 1, W3));
    add(0, 0, A4, 0, 0, 32'h40, 4'hF, 32'h55AA55AA, 1, W3, o_gi(A4, 0, 1, W3));
    add(0, 1, A4, 1, 0, 32'h40, 4'hF, 32'h55AA55AA, 0, W3, o_idle(W3));
    add(0, 1, A4, 1, 0, 32'h40, 4'hF, 32'h55AA55AA, 0, W3, o_gi(A4, 1, 0, W3));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check_o(i, sample(), vq[i].exp);
    end

    // Watchdog: TIMEOUT=8, fetch stalled 20 cycles.
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    i_read = 1'b1; i_address = 32'hBFC00040;
    m_waitrequest = 1'b1; m_readdata = W5;
    exp_q.push_back(W5);
    #1 check_w("t5_idle_iw", 32'(i_waitrequest), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      check_w("t5_stall_iw", 32'(i_waitrequest), 32'd1);
      check_w($sformatf("t5_te_k%0d", k), 32'(timeout_err), (k >= 8) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    m_waitrequest = 1'b0;
    #1;
    if (!i_waitrequest && exp_q.size() > 0) begin
      check_w("t5_readdata", i_readdata, exp_q.pop_front());
    end else begin
      checks++; errors++;
      $display("FAIL t5_complete: got i_waitrequest=%0d expected 0", i_waitrequest);
    end
    check_w("t5_te_done", 32'(timeout_err), 32'd1);
    @(negedge clk);
    i_read = 1'b0;
    #1;
    check_w("t5_idle_after_iw", 32'(i_waitrequest), 32'd1);
    check_w("t5_te_idle", 32'(timeout_err), 32'd1);
    repeat (3) @(negedge clk);
    #1 check_w("t5_te_sticky", 32'(timeout_err), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 check_w("t5_te_reset", 32'(timeout_err), 32'd0);

    // Asynchronous reset in the middle of a data write grant.
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    i_read = 1'b1; i_address = 32'hBFC00080;
    d_write = 1'b1; d_address = 32'h30; d_byteenable = 4'hC; d_writedata = 32'h11223344;
    @(negedge clk);
    reset = 1'b0;
    #1 check_w("t6_idle_iw", 32'(i_waitrequest), 32'd1);
    @(negedge clk);
    #1 check_w("t6_first_gnt_i", m_address, 32'hBFC00080);
    @(negedge clk);
    #1 check_w("t6_idle_dw", 32'(d_waitrequest), 32'd1);
    @(negedge clk);
    m_waitrequest = 1'b1;
    #1;
    check_w("t6_m_write", 32'(m_write), 32'd1);
    check_w("t6_m_be", 32'(m_byteenable), 32'hC);
    check_w("t6_m_wd", m_writedata, 32'h11223344);
    #2 reset = 1'b1;
    #1;
    check_w("t6_rst_m_write", 32'(m_write), 32'd0);
    check_w("t6_rst_m_addr", m_address, 32'h0);
    check_w("t6_rst_dw", 32'(d_waitrequest), 32'd1);
    check_w("t6_rst_iw", 32'(i_waitrequest), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    m_waitrequest = 1'b0;
    #1 check_w("t6_post_idle_mr", 32'(m_read), 32'd0);
    @(negedge clk);
    #1;
    check_w("t6_tie_i_addr", m_address, 32'hBFC00080);
    check_w("t6_tie_i_read", 32'(m_read), 32'd1);
    check_w("t6_tie_i_write", 32'(m_write), 32'd0);
    check_w("t6_tie_i_iw", 32'(i_waitrequest), 32'd0);
    check_w("t6_tie_i_dw", 32'(d_waitrequest), 32'd1);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
